// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiply job sequencer.
// Holds the FSM encoding, the operand width and the N = 2**M derivation.
package mm_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mm_state_e;

  function automatic int mm_n(input int m);
    return 1 << m;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: a sole requester wins; on a tie the
// requester that was not served last wins. last_i = index of last owner.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mm_seq_ctrl.sv
// Job sequencer feeding a shared multiplier: arbitrates two requesters, streams
// N*N operand pairs, then waits for the result-valid or a bounded timeout.
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int M       = 2,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  output logic [1:0]        grant,
  output logic [2*M-1:0]    idx,
  input  logic [DATA_W-1:0] a0_data,
  input  logic [DATA_W-1:0] b0_data,
  input  logic [DATA_W-1:0] a1_data,
  input  logic [DATA_W-1:0] b1_data,
  output logic [DATA_W-1:0] mm_a,
  output logic [DATA_W-1:0] mm_b,
  output logic              mm_en,
  input  logic              mm_en_out,
  output logic [1:0]        done,
  output logic              timeout,
  output logic              busy,
  output mm_state_e         dbg_state
);

  localparam int N      = mm_n(M);
  localparam int IDX_W  = 2 * M;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N * N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  mm_state_e         state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] mm_a_q, mm_a_d, mm_b_q, mm_b_d;
  logic              mm_en_q, mm_en_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tflag_q, tflag_d;
  logic              last_q, last_d;
  logic [1:0]        arb_gnt;

  rr_arb2 u_arb (
    .req_i  (req),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      idx_q   <= '0;
      mm_a_q  <= '0;
      mm_b_q  <= '0;
      mm_en_q <= 1'b0;
      cnt_q   <= '0;
      tflag_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      mm_a_q  <= mm_a_d;
      mm_b_q  <= mm_b_d;
      mm_en_q <= mm_en_d;
      cnt_q   <= cnt_d;
      tflag_q <= tflag_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    mm_a_d  = mm_a_q;
    mm_b_d  = mm_b_q;
    mm_en_d = 1'b0;
    cnt_d   = cnt_q;
    tflag_d = tflag_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        idx_d   = '0;
        cnt_d   = '0;
        tflag_d = 1'b0;
        if (req != 2'b00) begin
          state_d = ST_LOAD;
          grant_d = arb_gnt;
        end
      end
      ST_LOAD: begin
        // Operands for idx_q appear on mm_a/mm_b with mm_en one cycle later.
        mm_a_d  = grant_q[1] ? a1_data : a0_data;
        mm_b_d  = grant_q[1] ? b1_data : b0_data;
        mm_en_d = 1'b1;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_WAIT: begin
        // Counter stops at TIMEOUT because the FSM leaves WAIT on that edge.
        if (mm_en_out) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == CNT_MAX) begin
            state_d = ST_DONE;
            tflag_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
        last_d  = grant_q[1];
        tflag_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign grant     = grant_q;
  assign idx       = idx_q;
  assign mm_a      = mm_a_q;
  assign mm_b      = mm_b_q;
  assign mm_en     = mm_en_q;
  assign done      = (state_q == ST_DONE) ? grant_q : 2'b00;
  assign timeout   = (state_q == ST_DONE) && tflag_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
